uart_level_gen: RTL and testbench

Pulse-to-level converter for the UART configuration path; the counterpart of the level-to-pulse generator. A single-cycle event pulse, such as a receive-complete or config-write strobe, is turned into a level held for a programmable number of cycles or until the consumer acknowledges it. This lets slow or multi-cycle consumers (status registers, interrupt lines, LEDs) observe short events. The block also reports dropped events and natural expiry.

---
 rtl/uart_level_gen_pkg.sv | 14 +
 rtl/uart_level_gen_if.sv | 34 +++
 rtl/uart_level_gen_hold_counter.sv | 35 +++
 rtl/uart_level_gen.sv | 114 +++++++++++
 tb/tb_uart_level_gen.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/uart_level_gen_pkg.sv
// Shared types and constants for the UART pulse-to-level generator.
package uart_level_gen_pkg;

   // Level generator state; 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   // Default width of the hold-length input and down-counter.
   localparam int HOLD_W_DEF = 8;

endpackage : uart_level_gen_pkg

// File: rtl/uart_level_gen_if.sv
// Event/acknowledge bundle between an event source/consumer and uart_level_gen.
// master: the side producing events and acks; slave: the level generator.
interface uart_level_gen_if
   import uart_level_gen_pkg::*;
#(
   parameter int HOLD_W = HOLD_W_DEF
) ();

   logic              i_level_gen_pulse_sig;
   logic [HOLD_W-1:0] i_level_gen_hold_len;
   logic              i_level_gen_ack;
   logic              o_level_gen_lvl_sig;
   logic              o_level_gen_done;
   logic              o_level_gen_overrun;

   modport master (
      output i_level_gen_pulse_sig,
      output i_level_gen_hold_len,
      output i_level_gen_ack,
      input  o_level_gen_lvl_sig,
      input  o_level_gen_done,
      input  o_level_gen_overrun
   );

   modport slave (
      input  i_level_gen_pulse_sig,
      input  i_level_gen_hold_len,
      input  i_level_gen_ack,
      output o_level_gen_lvl_sig,
      output o_level_gen_done,
      output o_level_gen_overrun
   );

endinterface : uart_level_gen_if

// File: rtl/uart_level_gen_hold_counter.sv
// Loadable unsigned down-counter used to time the HOLD state.
// Load has priority over decrement; decrement saturates at zero.
module uart_hold_counter
   import uart_level_gen_pkg::*;
#(
   parameter int HOLD_W = HOLD_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [HOLD_W-1:0] i_load_val,
   input  logic              i_dec,
   output logic [HOLD_W-1:0] o_cnt,
   output logic              o_zero
);

   logic [HOLD_W-1:0] r_cnt;
   logic              w_zero;

   assign w_zero = (r_cnt == '0);
   assign o_cnt  = r_cnt;
   assign o_zero = w_zero;

   // Counter register: reset clears, load wins, decrement stops at zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && !w_zero) begin
         r_cnt <= r_cnt - HOLD_W'(1);
      end
   end

endmodule : uart_hold_counter

// File: rtl/uart_level_gen.sv
// Pulse-to-level converter: stretches a one-cycle event into a level held for
// a programmable number of cycles (hold_len) or until acknowledged (hold_len 0).
// Reports natural expiry (done) and events dropped while busy (overrun).
// Optional feature macro: UART_LEVEL_GEN_RETRIGGER_EN -- events while busy
// restart the hold instead of being dropped; overrun is then tied low.
module uart_level_gen
   import uart_level_gen_pkg::*;
#(
   parameter int HOLD_W = HOLD_W_DEF
) (
   input  logic           i_level_gen_clk,
   input  logic           i_level_gen_rst,
   uart_level_gen_if.slave bus
);

   state_t            r_state;
   state_t            w_next;
   logic              r_lvl;
   logic              r_done;
   logic              r_overrun;

   logic              w_accept;
   logic              w_drop;
   logic              w_load;
   logic              w_dec;
   logic              w_done_nxt;
   logic              w_hold_nz;
   logic [HOLD_W-1:0] w_load_val;
   logic [HOLD_W-1:0] w_cnt;
   logic              w_cnt_zero;

   assign w_hold_nz  = (bus.i_level_gen_hold_len != '0);
   assign w_load_val = bus.i_level_gen_hold_len - HOLD_W'(1);

`ifdef UART_LEVEL_GEN_RETRIGGER_EN
   assign w_accept = bus.i_level_gen_pulse_sig;
`else
   assign w_accept = bus.i_level_gen_pulse_sig && (r_state == IDLE);
`endif
   assign w_drop = bus.i_level_gen_pulse_sig && !w_accept;

   uart_hold_counter #(
      .HOLD_W (HOLD_W)
   ) u_cnt (
      .i_clk      (i_level_gen_clk),
      .i_rst      (i_level_gen_rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_cnt      (w_cnt),
      .o_zero     (w_cnt_zero)
   );

   // Next-state logic: an accepted event overrides ack and expiry.
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_dec      = 1'b0;
      w_done_nxt = 1'b0;
      if (w_accept) begin
         w_next = w_hold_nz ? HOLD : WAIT_ACK;
         w_load = w_hold_nz;
      end else begin
         case (r_state)
            HOLD: begin
               if (bus.i_level_gen_ack) begin
                  w_next = IDLE;
               end else if (w_cnt_zero) begin
                  w_next     = IDLE;
                  w_done_nxt = 1'b1;
               end else begin
                  w_dec = 1'b1;
               end
            end
            WAIT_ACK: begin
               if (bus.i_level_gen_ack) begin
                  w_next = IDLE;
               end
            end
            default: begin
               w_next = r_state;
            end
         endcase
      end
   end

   // State and registered outputs; a drop beats a same-cycle ack clear.
   always_ff @(posedge i_level_gen_clk) begin
      if (i_level_gen_rst) begin
         r_state   <= IDLE;
         r_lvl     <= 1'b0;
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_next;
         r_lvl   <= (w_next != IDLE);
         r_done  <= w_done_nxt;
`ifdef UART_LEVEL_GEN_RETRIGGER_EN
         r_overrun <= 1'b0;
`else
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (bus.i_level_gen_ack) begin
            r_overrun <= 1'b0;
         end
`endif
      end
   end

   assign bus.o_level_gen_lvl_sig = r_lvl;
   assign bus.o_level_gen_done    = r_done;
   assign bus.o_level_gen_overrun = r_overrun;

endmodule : uart_level_gen

// File: tb/tb_uart_level_gen.sv
// Directed bench for uart_level_gen: each step drives inputs, queues the
// outputs expected after the next clock edge, then pops and checks them.
module tb_uart_level_gen;
   import uart_level_gen_pkg::*;

`ifdef UART_LEVEL_GEN_RETRIGGER_EN
   localparam bit RT = 1'b1;
`else
   localparam bit RT = 1'b0;
`endif

   typedef struct {
      string tag;
      bit    lvl;
      bit    done;
      bit    ovr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   uart_level_gen_if #(.HOLD_W(8)) bus ();

   uart_level_gen #(.HOLD_W(8)) dut (
      .i_level_gen_clk (clk),
      .i_level_gen_rst (rst),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input string sig, input logic obs, input bit exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s %s: observed %b expected %b", tag, sig, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit p, input logic [7:0] h, input bit a,
                       input bit el, input bit ed, input bit eo, input string tag);
      exp_t e;
      rst = r;
      bus.i_level_gen_pulse_sig = p;
      bus.i_level_gen_hold_len  = h;
      bus.i_level_gen_ack       = a;
      sb.push_back('{tag, el, ed, eo});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk(e.tag, "lvl",     bus.o_level_gen_lvl_sig, e.lvl);
      chk(e.tag, "done",    bus.o_level_gen_done,    e.done);
      chk(e.tag, "overrun", bus.o_level_gen_overrun, e.ovr);
   endtask

   initial begin
      bus.i_level_gen_pulse_sig = 1'b0;
      bus.i_level_gen_hold_len  = 8'd0;
      bus.i_level_gen_ack       = 1'b0;

      // Reset held two cycles with pulse high.
      step(1, 1, 8'd3, 0, 0, 0, 0, "rst0");
      step(1, 1, 8'd3, 0, 0, 0, 0, "rst1");
      vectors++;
      assert (dut.r_state === IDLE) else begin
         miscompares++;
         $error("FAIL rst_state: observed %0d expected %0d", dut.r_state, IDLE);
      end
      vectors++;
      assert (dut.u_cnt.r_cnt === 8'd0) else begin
         miscompares++;
         $error("FAIL rst_cnt: observed %0d expected 0", dut.u_cnt.r_cnt);
      end
      step(0, 0, 8'd3, 1, 0, 0, 0, "idle_ack");

      // Timed hold of 3; hold_len changes while busy must be ignored.
      step(0, 1, 8'd3, 0, 1, 0, 0, "t3_e0");
      step(0, 0, 8'd1, 0, 1, 0, 0, "t3_e1");
      step(0, 0, 8'd1, 0, 1, 0, 0, "t3_e2");
      step(0, 0, 8'd1, 0, 0, 1, 0, "t3_e3");
      step(0, 0, 8'd1, 0, 0, 0, 0, "t3_e4");

      // Early ack at E4 with hold 10.
      step(0, 1, 8'd10, 0, 1, 0, 0, "ea_e0");
      for (int i = 1; i < 4; i++) step(0, 0, 8'd10, 0, 1, 0, 0, "ea_hold");
      step(0, 0, 8'd10, 1, 0, 0, 0, "ea_ack");
      for (int i = 0; i < 8; i++) step(0, 0, 8'd10, 0, 0, 0, 0, "ea_after");

      // Ack mode: hold until ack at E300.
      step(0, 1, 8'd0, 0, 1, 0, 0, "am_e0");
      for (int i = 1; i < 300; i++) step(0, 0, 8'd0, 0, 1, 0, 0, "am_wait");
      step(0, 0, 8'd0, 1, 0, 0, 0, "am_ack");
      step(0, 0, 8'd0, 0, 0, 0, 0, "am_after");

      // Second pulse at E2 with hold 5: dropped or retriggered.
      step(0, 1, 8'd5, 0, 1, 0, 0, "dr_e0");
      step(0, 0, 8'd5, 0, 1, 0, 0, "dr_e1");
      step(0, 1, 8'd5, 0, 1, 0, !RT, "dr_e2");
      step(0, 0, 8'd5, 0, 1, 0, !RT, "dr_e3");
      step(0, 0, 8'd5, 0, 1, 0, !RT, "dr_e4");
      step(0, 0, 8'd5, 0, RT, !RT, !RT, "dr_e5");
      step(0, 0, 8'd5, 0, RT, 0, !RT, "dr_e6");
      step(0, 0, 8'd5, 0, 0, RT, !RT, "dr_e7");
      step(0, 0, 8'd5, 1, 0, 0, 0, "dr_e8");
      step(0, 0, 8'd5, 0, 0, 0, 0, "dr_e9");

      // Hold 1, pulse on the expiry cycle, then in the first idle cycle.
      step(0, 1, 8'd1, 0, 1, 0, 0, "bb_e0");
      step(0, 1, 8'd1, 0, RT, !RT, !RT, "bb_e1");
      step(0, 1, 8'd1, 0, 1, 0, !RT, "bb_e2");
      step(0, 0, 8'd1, 1, 0, 0, 0, "bb_e3");

      // Pulse and ack together while waiting for ack.
      step(0, 1, 8'd0, 0, 1, 0, 0, "pa_e0");
      step(0, 1, 8'd0, 1, RT, 0, !RT, "pa_e1");
      step(0, 0, 8'd0, 1, 0, 0, 0, "pa_e2");

      // Continuous pulse input, hold 2.
      step(0, 1, 8'd2, 0, 1, 0, 0, "cp_e0");
      step(0, 1, 8'd2, 0, 1, 0, !RT, "cp_e1");
      step(0, 1, 8'd2, 0, RT, !RT, !RT, "cp_e2");
      step(0, 1, 8'd2, 0, 1, 0, !RT, "cp_e3");
      step(0, 0, 8'd2, 0, 1, 0, !RT, "cp_e4");
      step(0, 0, 8'd2, 0, 0, 1, !RT, "cp_e5");
      step(0, 0, 8'd2, 1, 0, 0, 0, "cp_e6");

      // Maximum hold of 255 cycles.
      step(0, 1, 8'd255, 0, 1, 0, 0, "mx_e0");
      for (int i = 1; i < 255; i++) step(0, 0, 8'd255, 0, 1, 0, 0, "mx_hold");
      step(0, 0, 8'd255, 0, 0, 1, 0, "mx_end");
      step(0, 0, 8'd255, 0, 0, 0, 0, "mx_after");

      // Reset mid-hold with a pending pulse.
      step(0, 1, 8'd5, 0, 1, 0, 0, "rm_e0");
      step(1, 1, 8'd5, 0, 0, 0, 0, "rm_rst");
      step(0, 0, 8'd5, 0, 0, 0, 0, "rm_e2");
      vectors++;
      assert (dut.u_cnt.r_cnt === 8'd0) else begin
         miscompares++;
         $error("FAIL rm_cnt: observed %0d expected 0", dut.u_cnt.r_cnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_uart_level_gen
